keccak_msg_packer: RTL
======================

# keccak_msg_packer

Byte-stream front end for the `keccak` SHA3-512 core: accepts a message one byte at a time over a valid/ready handshake, packs bytes into 64-bit words and drives the core's word-input port (`in`, `in_ready`, `is_last`, `byte_num`), honouring `buffer_full`. Before each message it issues the core's reset. After the message it waits for `out_ready` and reports completion. It sits between the AXI register/FIFO side and the hash core in the Kyber hashing path.

## Interface
- `KC_RST_CYCLES`, default 1: number of cycles the core's `reset` is held high at message start (1..7).
- `clk` in 1: clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a new message (ignored unless state is IDLE or DONE).
- `s_data` in 8: message byte.
- `s_valid` in 1: byte/terminator present.
- `s_null` in 1: with `s_valid`, entry carries no byte (only meaningful with `s_last`; used for zero-length tail).
- `s_last` in 1: final entry of the message.
- `s_ready` out 1: packer can accept an entry.
- `kc_reset` out 1: to core `reset` (active-high, synchronous in core).
- `kc_in` out 64: to core `in`; first byte of a word in [63:56].
- `kc_in_ready` out 1: to core `in_ready`.
- `kc_is_last` out 1: to core `is_last`.
- `kc_byte_num` out 3: to core `byte_num`.
- `kc_buffer_full` in 1: from core `buffer_full`.
- `kc_out_ready` in 1: from core `out_ready`.
- `busy` out 1: high from `start` accept until DONE.
- `msg_done` out 1: high in DONE (level) until next `start`.

## Operation
- States: IDLE, KRST, FILL, SEND, PAD, WAIT, DONE.
- IDLE/DONE + `start` -> KRST; `kc_reset`=1 for `KC_RST_CYCLES` cycles, byte counter and word register cleared -> FILL.
- FILL: `s_ready`=1. Entry accepted on `s_valid && s_ready`. Non-null byte written to lane `cnt` (lane 0 = [63:56]), `cnt`++. Unused lanes read 0.
- FILL exit: after 8th byte -> SEND with `last_pending = s_last`; after `s_last` with 1..7 bytes (`cnt` after write) -> SEND with `kc_is_last`=1, `kc_byte_num`=cnt; after `s_last` with `cnt`=0 (null entry, or message multiple of 8) -> PAD.
- SEND: `kc_in_ready`=1, `s_ready`=0; word transfers in a cycle with `kc_in_ready && !kc_buffer_full`. On transfer: if this word was last -> WAIT; else if `last_pending` -> PAD; else clear `cnt` -> FILL.
- PAD: `kc_in`=0, `kc_is_last`=1, `kc_byte_num`=0, `kc_in_ready`=1; transfers under same rule -> WAIT.
- WAIT: `kc_in_ready`=0; on `kc_out_ready`=1 -> DONE. Digest itself is read directly from the core's `out`.
- `s_null` without `s_last` in FILL: accepted and discarded.
- `start` in FILL/SEND/PAD/WAIT: ignored.

## Timing
- Reset values: state IDLE; `s_ready`, `kc_reset`, `kc_in_ready`, `kc_is_last`, `busy`, `msg_done` = 0; `kc_in`=0, `kc_byte_num`=0.
- All outputs registered or decoded from state; no combinational path from `kc_buffer_full` to `kc_in`/`kc_is_last`/`kc_byte_num`.
- Word presented the cycle after its final byte is accepted. Held stable (all four `kc_*` data signals) while `kc_buffer_full`=1.
- Steady-state throughput: 8 bytes per 9 cycles (8 FILL + 1 SEND) when `kc_buffer_full`=0.
- `kc_is_last` is high only together with `kc_in_ready`, for exactly one transfer per message.
- `reset_n` low mid-message: immediate return to IDLE, all outputs to reset values; core reset is issued on the next `start`.

## Structure
- Shared package: state encoding, `LANE_W`=8, `WORD_W`=64, `LANES`=8.
- Single module. No sub-module needed; lane write and counter logic are inline.

## Test plan
- "The quick brown fox jumps over the lazy dog" (43 bytes): 5 full words, then `kc_in`=64'h646f670000000000 with `is_last`=1, `byte_num`=3. Digest = 01dedd5de4ef...0d450; `msg_done`=1.
- Bytes A1..A5, `s_last` on A5: single word 64'hA1A2A3A4A5000000, `is_last`=1, `byte_num`=5. Digest = edc8d5dd...af43f9.
- 8 bytes c20634f357f421fb, `s_last` on 8th: word with `is_last`=0, then PAD word 0 with `is_last`=1, `byte_num`=0. Digest = cad2093f...b147c3.
- 64-byte message c20634f3...f37e4f42 with `kc_buffer_full` forced high for 5 cycles mid-stream: no word lost or duplicated, `kc_in` stable during the stall. Digest = 82d7b805...cd20a4.
- Zero-length: `start`, then a single null+last entry -> PAD word only (`byte_num`=0); `msg_done` rises after `kc_out_ready`.
- `reset_n` asserted during SEND: all outputs 0 asynchronously. Next `start` pulses `kc_reset`, and a clean A1..A5 hash completes correctly.

Source files
------------

// File: rtl/keccak_msg_packer_pkg.sv
// Shared definitions for the keccak message packer: word geometry and the
// controller state encoding.
package keccak_msg_packer_pkg;

   localparam int LANE_W = 8;
   localparam int WORD_W = 64;
   localparam int LANES  = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_KRST = 3'd1,
      ST_FILL = 3'd2,
      ST_SEND = 3'd3,
      ST_PAD  = 3'd4,
      ST_WAIT = 3'd5,
      ST_DONE = 3'd6
   } state_e;

endpackage

// File: rtl/keccak_msg_packer.sv
// Byte-stream front end for the keccak SHA3-512 core. Bytes arrive over a
// valid/ready handshake, are packed big-endian into 64-bit words and handed to
// the core's word port. A message always ends with exactly one is_last word:
// either the partial final word, or an all-zero PAD word when the message
// length is a multiple of 8 (including zero).
module keccak_msg_packer
   import keccak_msg_packer_pkg::*;
#(
   parameter int KC_RST_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   input  logic              s_null,
   input  logic              s_last,
   output logic              s_ready,
   output logic              kc_reset,
   output logic [63:0]       kc_in,
   output logic              kc_in_ready,
   output logic              kc_is_last,
   output logic [2:0]        kc_byte_num,
   input  logic              kc_buffer_full,
   input  logic              kc_out_ready,
   output logic              busy,
   output logic              msg_done
);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;           // bytes held in word_q (0..8)
   logic [2:0]          rst_cnt_q, rst_cnt_d;   // core reset cycles elapsed
   logic [WORD_W-1:0]   word_q, word_d;
   logic                last_pending_q, last_pending_d;  // full word ended the message
   logic                word_last_q, word_last_d;        // word_q is the is_last word
   logic [2:0]          byte_num_q, byte_num_d;

   logic [3:0]          cnt_inc;

   // Byte count after the entry offered this cycle (null entries add nothing).
   assign cnt_inc = cnt_q + {3'd0, ~s_null};

   // Next-state, lane write and counter logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rst_cnt_d      = rst_cnt_q;
      word_d         = word_q;
      last_pending_d = last_pending_q;
      word_last_d    = word_last_q;
      byte_num_d     = byte_num_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d        = ST_KRST;
               rst_cnt_d      = 3'd0;
               cnt_d          = 4'd0;
               word_d         = '0;
               last_pending_d = 1'b0;
               word_last_d    = 1'b0;
               byte_num_d     = 3'd0;
            end
         end

         ST_KRST: begin
            if (rst_cnt_q == 3'(KC_RST_CYCLES - 1)) begin
               state_d = ST_FILL;
            end else begin
               rst_cnt_d = rst_cnt_q + 3'd1;
            end
         end

         ST_FILL: begin
            if (s_valid) begin
               if (!s_null) begin
                  for (int i = 0; i < LANES; i++) begin
                     if (cnt_q[2:0] == 3'(i)) begin
                        word_d[WORD_W-1-i*LANE_W -: LANE_W] = s_data;
                     end
                  end
               end
               cnt_d = cnt_inc;
               if (cnt_inc == 4'd8) begin
                  state_d        = ST_SEND;
                  last_pending_d = s_last;
                  word_last_d    = 1'b0;
                  byte_num_d     = 3'd0;
               end else if (s_last) begin
                  if (cnt_inc != 4'd0) begin
                     state_d     = ST_SEND;
                     word_last_d = 1'b1;
                     byte_num_d  = cnt_inc[2:0];
                  end else begin
                     state_d = ST_PAD;
                  end
               end
            end
         end

         ST_SEND: begin
            if (!kc_buffer_full) begin
               if (word_last_q) begin
                  state_d = ST_WAIT;
               end else if (last_pending_q) begin
                  state_d = ST_PAD;
               end else begin
                  state_d = ST_FILL;
               end
               cnt_d          = 4'd0;
               word_d         = '0;
               last_pending_d = 1'b0;
               word_last_d    = 1'b0;
               byte_num_d     = 3'd0;
            end
         end

         ST_PAD: begin
            if (!kc_buffer_full) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (kc_out_ready) begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 4'd0;
         rst_cnt_q      <= 3'd0;
         word_q         <= '0;
         last_pending_q <= 1'b0;
         word_last_q    <= 1'b0;
         byte_num_q     <= 3'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rst_cnt_q      <= rst_cnt_d;
         word_q         <= word_d;
         last_pending_q <= last_pending_d;
         word_last_q    <= word_last_d;
         byte_num_q     <= byte_num_d;
      end
   end

   // Outputs decode only registered state, so kc_buffer_full never reaches
   // the word signals combinationally and they hold steady during a stall.
   assign s_ready     = (state_q == ST_FILL);
   assign kc_reset    = (state_q == ST_KRST);
   assign kc_in_ready = (state_q == ST_SEND) || (state_q == ST_PAD);
   assign kc_in       = (state_q == ST_SEND) ? word_q : '0;
   assign kc_is_last  = (state_q == ST_PAD) || ((state_q == ST_SEND) && word_last_q);
   assign kc_byte_num = ((state_q == ST_SEND) && word_last_q) ? byte_num_q : 3'd0;
   assign busy        = (state_q == ST_KRST) || (state_q == ST_FILL) ||
                        (state_q == ST_SEND) || (state_q == ST_PAD)  ||
                        (state_q == ST_WAIT);
   assign msg_done    = (state_q == ST_DONE);

endmodule
